// File: rtl/net_eject_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : net_eject_port_pkg
// Description : Shared network packet type, state encoding and size defaults
//               for the per-node ejection port.
// Revision    : 1.0 - initial release
// ============================================================================
package net_eject_port_pkg;

  localparam int NUMNODES   = 8;
  localparam int PKT_W_DEF  = 576;
  localparam int BEAT_W_DEF = 64;

  // src occupies the top byte and dest the next byte; payload fills the LSBs
  typedef struct packed {
    logic [7:0]             src;
    logic [7:0]             dest;
    logic [PKT_W_DEF-17:0]  payload;
  } pkt_t;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } eject_state_t;

endpackage : net_eject_port_pkg
`default_nettype wire

// File: rtl/net_eject_port_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eject_fifo
// Description : Synchronous packet FIFO with combinational head output;
//               push and pop may coincide, including when full.
// Revision    : 1.0 - initial release
// ============================================================================
module eject_fifo #(
  parameter int WIDTH = 576,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;

  // Storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign full      = (r_count == c_cw'(DEPTH));
  assign empty     = (r_count == '0);

endmodule : eject_fifo
`default_nettype wire

// File: rtl/net_eject_port.sv
`default_nettype none
// ============================================================================
// Module      : net_eject_port
// Description : Crossbar ejection stage: buffers delivered packets and streams
//               them to the node as valid/ready beats, flagging drops.
// Revision    : 1.0 - initial release
// ============================================================================
module net_eject_port
  import net_eject_port_pkg::*;
#(
  parameter int NODE_ID      = 0,
  parameter int DEPTH        = 4,
  parameter int PKT_W        = PKT_W_DEF,
  parameter int BEAT_W       = BEAT_W_DEF,
  parameter int AFULL_THRESH = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pkt_valid_in,
  input  logic [PKT_W-1:0]                  pkt_in,
  output logic                              beat_valid,
  output logic [BEAT_W-1:0]                 beat_data,
  output logic [$clog2(PKT_W/BEAT_W)-1:0]   beat_idx,
  output logic                              beat_last,
  input  logic                              beat_ready,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              almost_full,
  output logic                              overflow,
  output logic                              misroute,
  output logic [15:0]                       drop_count
);

  localparam int         c_nbeats  = PKT_W / BEAT_W;
  localparam int         c_iw      = $clog2(c_nbeats);
  localparam logic [7:0] c_node_id = NODE_ID[7:0];

  pkt_t                              w_pkt;
  logic                              w_dest_ok;
  logic                              w_push;
  logic                              w_pop;
  logic                              w_drop;
  logic                              w_full;
  logic                              w_empty;
  logic [PKT_W-1:0]                  w_head;
  logic [c_nbeats-1:0][BEAT_W-1:0]   w_beats;
  eject_state_t                      r_state;
  eject_state_t                      w_state_next;
  logic [c_iw-1:0]                   r_beat_idx;
  logic [c_iw-1:0]                   w_beat_idx_next;

  assign w_pkt     = pkt_in;
  assign w_dest_ok = (w_pkt.dest == c_node_id);

  // A pop on the same edge frees the slot, so a full FIFO may still accept
  assign w_pop  = beat_valid & beat_ready & beat_last;
  assign w_push = pkt_valid_in & w_dest_ok & (~w_full | w_pop);
  assign w_drop = pkt_valid_in & w_dest_ok & w_full & ~w_pop;

  eject_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (pkt_in),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign w_beats     = w_head;
  assign beat_valid  = (r_state == S_STREAM);
  assign beat_idx    = r_beat_idx;
  assign beat_data   = beat_valid ? w_beats[r_beat_idx] : '0;
  assign beat_last   = beat_valid & (r_beat_idx == c_iw'(c_nbeats - 1));
  assign almost_full = (DEPTH - int'(count)) <= AFULL_THRESH;

  always_comb begin
    w_state_next    = r_state;
    w_beat_idx_next = r_beat_idx;
    case (r_state)
      S_IDLE: begin
        if (!w_empty || w_push) w_state_next = S_STREAM;
      end
      S_STREAM: begin
        if (beat_ready) begin
          if (beat_last) begin
            w_beat_idx_next = '0;
            // Occupancy after this pop is zero only if nothing else is queued
            if (count == $bits(count)'(1) && !w_push) w_state_next = S_IDLE;
          end else begin
            w_beat_idx_next = r_beat_idx + c_iw'(1);
          end
        end
      end
      default: begin
        w_state_next    = S_IDLE;
        w_beat_idx_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_beat_idx <= '0;
      overflow   <= 1'b0;
      misroute   <= 1'b0;
      drop_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_idx <= w_beat_idx_next;
      if (pkt_valid_in && !w_dest_ok) misroute <= 1'b1;
      if (w_drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule : net_eject_port
`default_nettype wire

// File: tb/tb_net_eject_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_net_eject_port
// Description : Self-checking bench for net_eject_port (NODE_ID=2, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_net_eject_port;

  localparam int NB    = 9;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         pkt_valid_in;
  logic [575:0] pkt_in;
  logic         beat_valid;
  logic [63:0]  beat_data;
  logic [3:0]   beat_idx;
  logic         beat_last;
  logic         beat_ready;
  logic [2:0]   count;
  logic         almost_full;
  logic         overflow;
  logic         misroute;
  logic [15:0]  drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  net_eject_port #(
    .NODE_ID      (2),
    .DEPTH        (DEPTH),
    .PKT_W        (576),
    .BEAT_W       (64),
    .AFULL_THRESH (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid_in (pkt_valid_in),
    .pkt_in       (pkt_in),
    .beat_valid   (beat_valid),
    .beat_data    (beat_data),
    .beat_idx     (beat_idx),
    .beat_last    (beat_last),
    .beat_ready   (beat_ready),
    .count        (count),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .misroute     (misroute),
    .drop_count   (drop_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet with 64-bit chunk k = {tag, 0x1000+k}; src=tag byte, dest in bits 567:560
  function automatic logic [575:0] mk(input logic [7:0] dest, input logic [15:0] tag);
    logic [575:0] p;
    p = '0;
    for (int k = 0; k < NB; k++) p[k*64 +: 64] = {16'h0, tag, 32'h1000 + k};
    p[575:568] = tag[7:0];
    p[567:560] = dest;
    return p;
  endfunction

  // Reference model: queue of packets, head streamed beat by beat
  logic [575:0] mq[$];
  int           m_idx;
  bit           m_ovf, m_mis, m_live = 0;
  int           m_drop;
  bit           m_last;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_idx = 0; m_ovf = 0; m_mis = 0; m_drop = 0; m_live = 1;
    end else if (m_live) begin
      m_last = (mq.size() != 0) && beat_ready && (m_idx == NB-1);
      if (mq.size() != 0 && beat_ready) begin
        if (m_last) begin void'(mq.pop_front()); m_idx = 0; end
        else m_idx++;
      end
      if (pkt_valid_in) begin
        if (pkt_in[567:560] != 8'd2) m_mis = 1;
        else if (mq.size() < DEPTH) mq.push_back(pkt_in);
        else begin m_ovf = 1; if (m_drop < 65535) m_drop++; end
      end
    end
  end

  logic [575:0] m_head;
  bit           m_v;
  always @(negedge clk) begin
    if (m_live) begin
      m_v    = (mq.size() != 0);
      m_head = m_v ? mq[0] : '0;
      check("m_valid", beat_valid, m_v);
      check("m_data", beat_data, m_v ? m_head[m_idx*64 +: 64] : 64'h0);
      check("m_idx", beat_idx, m_idx);
      check("m_last", beat_last, m_v && (m_idx == NB-1));
      check("m_count", count, mq.size());
      check("m_afull", almost_full, (DEPTH - mq.size()) <= 1);
      check("m_ovf", overflow, m_ovf);
      check("m_mis", misroute, m_mis);
      check("m_drop", drop_count, m_drop);
    end
  end

  task automatic wait_idx(input int idx, input string name);
    int n = 0;
    while (!(beat_valid && beat_idx == idx) && n < 40) begin @(negedge clk); n++; end
    check(name, {beat_valid, beat_idx}, {1'b1, 4'(idx)});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (beat_valid && n < 80) begin @(negedge clk); n++; end
    check(name, {beat_valid, count}, 4'b0);
  endtask

  logic [63:0] beats [NB];
  logic        lasts [NB];
  logic [63:0] firsts [4];
  int          nf;

  initial begin
    rst = 1'b1; pkt_valid_in = 1'b0; pkt_in = '0; beat_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", beat_valid, 0);
    check("rst_count", count, 0);
    check("rst_afull", almost_full, 0);

    // Single packet, full throughput
    beat_ready = 1'b1;
    pkt_in = mk(8'd2, 16'h0); pkt_valid_in = 1'b1;
    @(negedge clk); pkt_valid_in = 1'b0;
    check("t1_latency", beat_valid, 1);
    for (int k = 0; k < NB; k++) begin
      beats[k] = beat_data; lasts[k] = beat_last;
      @(negedge clk);
    end
    check("t1_beat0", beats[0], 64'h1000);
    check("t1_beat4", beats[4], 64'h1004);
    check("t1_beat8", beats[8], 64'h0002_0000_0000_1008);
    check("t1_last7", lasts[7], 0);
    check("t1_last8", lasts[8], 1);
    check("t1_idle", {beat_valid, count}, 4'b0);

    // Backpressure at beat 3
    pkt_in = mk(8'd2, 16'h1); pkt_valid_in = 1'b1;
    @(negedge clk); pkt_valid_in = 1'b0;
    wait_idx(3, "t2_reach3");
    beat_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t2_hold", {beat_valid, beat_idx}, {1'b1, 4'd3});
      check("t2_hold_data", beat_data, 64'h0000_0001_0000_1003);
    end
    beat_ready = 1'b1;
    @(negedge clk);
    check("t2_resume", beat_idx, 4);
    wait_idle("t2_drain");

    // Overflow: six arrivals with the consumer stalled
    beat_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pkt_in = mk(8'd2, 16'(10 + i)); pkt_valid_in = 1'b1;
      @(negedge clk);
      if (i == 1) check("t3_afull_c2", almost_full, 0);
      if (i == 2) check("t3_afull_c3", {count, almost_full}, {3'd3, 1'b1});
    end
    pkt_valid_in = 1'b0;
    check("t3_count", count, 4);
    check("t3_flags", {overflow, almost_full}, 2'b11);
    check("t3_drops", drop_count, 2);
    check("t3_head", beat_data, 64'h0000_000A_0000_1000);

    // Full FIFO: new arrival coincides with the head's last beat
    beat_ready = 1'b1;
    wait_idx(8, "t4_reach8");
    pkt_in = mk(8'd2, 16'd20); pkt_valid_in = 1'b1;
    @(negedge clk); pkt_valid_in = 1'b0;
    check("t4_count", count, 4);
    check("t4_drops", drop_count, 2);
    nf = 0;
    for (int n = 0; n < 60 && nf < 4; n++) begin
      if (beat_valid && beat_idx == 0) begin firsts[nf] = beat_data; nf++; end
      @(negedge clk);
    end
    check("t4_n", nf, 4);
    check("t4_p0", firsts[0], 64'h0000_000B_0000_1000);
    check("t4_p1", firsts[1], 64'h0000_000C_0000_1000);
    check("t4_p2", firsts[2], 64'h0000_000D_0000_1000);
    check("t4_p3", firsts[3], 64'h0000_0014_0000_1000);
    wait_idle("t4_drain");

    // Misroute
    pkt_in = mk(8'd5, 16'd30); pkt_valid_in = 1'b1;
    @(negedge clk); pkt_valid_in = 1'b0;
    check("t5_mis", misroute, 1);
    check("t5_count", {beat_valid, count}, 4'b0);
    check("t5_drops", drop_count, 2);

    // Reset mid-stream with two packets queued
    pkt_in = mk(8'd2, 16'd40); pkt_valid_in = 1'b1;
    @(negedge clk);
    pkt_in = mk(8'd2, 16'd41);
    @(negedge clk); pkt_valid_in = 1'b0;
    wait_idx(4, "t6_reach4");
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t6_outs", {beat_valid, beat_idx, beat_last, count}, 9'b0);
    check("t6_data", beat_data, 0);
    check("t6_flags", {overflow, misroute, drop_count}, 18'b0);
    pkt_in = mk(8'd2, 16'd50); pkt_valid_in = 1'b1;
    @(negedge clk); pkt_valid_in = 1'b0;
    check("t6_restart", {beat_valid, beat_idx}, {1'b1, 4'd0});
    check("t6_data0", beat_data, 64'h0000_0032_0000_1000);
    wait_idle("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_net_eject_port
`default_nettype wire

// File: doc/net_eject_port.md
Name: net_eject_port

Overview:
- Per-node ejection stage directly downstream of the crossbar.
- Captures the one-cycle received pulse and packet for its node, buffers packets in a small FIFO, and streams each packet to the node-side consumer as 64-bit beats under a valid/ready handshake.
- Flags overflow and misrouted packets, because the crossbar output cannot be back-pressured.

Parameters:
- NODE_ID, 0, this node's 8-bit ID; compared against the packet dest field.
- DEPTH, 4, packet FIFO entries (power of two, >= 2).
- PKT_W, 576, packet width; equals $bits(pkt_t).
- BEAT_W, 64, output beat width; PKT_W must be a multiple of BEAT_W.
- AFULL_THRESH, 1, almost_full asserts when free slots <= this value.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- pkt_valid_in, input, 1, one-cycle pulse: packet delivered to this node this cycle.
- pkt_in, input, PKT_W (pkt_t), packet delivered by the crossbar.
- beat_valid, output, 1, beat_data is valid.
- beat_data, output, BEAT_W, current beat of the head packet.
- beat_idx, output, $clog2(PKT_W/BEAT_W), index of the current beat.
- beat_last, output, 1, current beat is the final beat of the packet.
- beat_ready, input, 1, consumer accepts the beat this cycle.
- count, output, $clog2(DEPTH+1), packets held in the FIFO.
- almost_full, output, 1, (DEPTH - count) <= AFULL_THRESH.
- overflow, output, 1, sticky: a packet was dropped because the FIFO was full.
- misroute, output, 1, sticky: a packet arrived with dest != NODE_ID.
- drop_count, output, 16, saturating count of overflow drops.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO emptied, beat counter 0, FSM to IDLE.
  - All outputs 0: beat_valid, beat_data, beat_idx, beat_last, count, overflow, misroute, drop_count; almost_full is 0 when AFULL_THRESH < DEPTH.
  - Reset mid-stream discards the in-flight packet; no partial beats resume.
- Accept rule, evaluated when pkt_valid_in=1:
  - dest != NODE_ID: drop, set misroute; FIFO and drop_count unchanged.
  - Else, FIFO not full, or full with a pop in the same cycle: write the packet.
  - Else: drop, set overflow, drop_count += 1, saturating at 16'hFFFF.
- Pop: occurs when beat_valid & beat_ready & beat_last.
  - Simultaneous push and pop leaves count unchanged.
  - Push into an empty FIFO makes the packet visible as beat 0 on the next cycle (latency 1).
- FSM, two states:
  - IDLE: beat_valid=0. Go to STREAM when count != 0.
  - STREAM: beat_valid=1, beat_data = head[beat_idx*BEAT_W +: BEAT_W], LSB beat first.
    - Handshake beat_valid & beat_ready: beat_idx increments.
    - On the last beat: beat_idx returns to 0 and the FIFO pops. Stay in STREAM if count after the pop != 0, else go to IDLE.
- Valid/ready rules:
  - While beat_valid=1 and beat_ready=0, beat_data, beat_idx and beat_last hold stable.
  - beat_valid never drops without a handshake, except on reset.
  - beat_ready while in IDLE has no effect.
- beat_last = (beat_idx == PKT_W/BEAT_W - 1) & beat_valid.
- Sticky flags clear only on reset.
- FIFO pointers wrap modulo DEPTH.

Decomposition:
- NetworkPkg holds pkt_t (src[7:0], dest[7:0], payload), NUMNODES, PKT_W and BEAT_W defaults.
- One sub-module: eject_fifo, a synchronous FIFO parameterised by WIDTH/DEPTH.
  - Outputs: count, full, empty.
  - Must support push-when-full in the same cycle as a pop.
  - Head data is available combinationally.
- FSM, beat counter, accept logic and counters live in net_eject_port.

Test Plan:
- Single packet, NODE_ID=2: payload beat k = 64'h1000+k, dest=2, beat_ready=1 -> beat_valid rises 1 cycle after the pulse, 9 beats idx 0..8 carry 64'h1000..64'h1008, beat_last only on idx 8, count returns to 0.
- Backpressure: beat_ready low for 5 cycles mid-packet at idx 3 -> beat_data/idx held at 3 with beat_valid=1 throughout; stream resumes at idx 3 when ready rises.
- Overflow: beat_ready=0, 6 valid pulses, DEPTH=4 -> count=4, almost_full=1 from count=3, overflow=1, drop_count=2; draining yields the first 4 packets in order.
- Full with simultaneous push/pop: FIFO full, new packet arrives in the same cycle the last beat of the head is accepted -> packet accepted, count stays 4, drop_count unchanged.
- Misroute: packet with dest=5 at NODE_ID=2 -> misroute=1, count unchanged, drop_count unchanged, no beats emitted.
- Reset mid-stream: rst asserted at beat idx 4 with 2 packets queued -> the next cycle shows all outputs 0 and count=0; a later valid packet streams from idx 0.
